// File: rtl/bitty_fetch_if.sv
// Bundle of host load/start controls, core handshake and status for bitty_fetch.
// The master side is the host plus the bitty core; the slave side is the sequencer.
interface bitty_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              done;
    logic [15:0]       d_out;
    logic [15:0]       d_instr;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       result;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        output load_en, load_addr, load_data, start, prog_len, done, d_out,
        input  d_instr, run, pc, result, busy, halted, err
    );

    modport slave (
        input  load_en, load_addr, load_data, start, prog_len, done, d_out,
        output d_instr, run, pc, result, busy, halted, err
    );
endinterface

// File: rtl/bitty_fetch.sv
// Program sequencer for the bitty core: holds a loadable instruction memory, walks
// it from address 0 on start, handshakes each word with the core and guards with a watchdog.
module bitty_fetch #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    bitty_fetch_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT,
        S_ERR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  wd_q;
    logic [15:0]       instr_q;
    logic [15:0]       result_q;
    logic              idle_like;
    logic              start_ok;
    logic              last_instr;
    logic              wd_expired;
    logic              run_c;
    logic              busy_c;
    logic              halted_c;
    logic              err_c;

    assign idle_like  = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR);
    assign start_ok   = idle_like && bus.start;
    // Compare one bit wider than pc so a full-memory program ends without wrapping.
    assign last_instr = (({1'b0, pc_q} + (ADDR_W + 1)'(1)) == len_q);
    assign wd_expired = (wd_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_c    = 1'b0;
        busy_c   = 1'b0;
        halted_c = 1'b0;
        err_c    = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                halted_c = (state_q == S_HALT);
                err_c    = (state_q == S_ERR);
                if (bus.start) begin
                    state_d = (bus.prog_len == '0) ? S_HALT : S_FETCH;
                end
            end
            S_FETCH: begin
                busy_c  = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                busy_c  = 1'b1;
                run_c   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy_c = 1'b1;
                // Completion wins over a watchdog expiring on the same edge.
                if (bus.done) begin
                    state_d = last_instr ? S_HALT : S_FETCH;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory contents survive reset, so the write port carries no reset.
    always_ff @(posedge clk) begin
        if (bus.load_en && idle_like) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            pc_q     <= '0;
            wd_q     <= '0;
            instr_q  <= '0;
            result_q <= '0;
        end else begin
            if (start_ok) begin
                len_q <= bus.prog_len;
                pc_q  <= '0;
            end
            if (state_q == S_FETCH) begin
                instr_q <= mem[pc_q];
            end
            if (state_q == S_ISSUE) begin
                wd_q <= '0;
            end else if ((state_q == S_WAIT) && !wd_expired) begin
                wd_q <= wd_q + CNT_W'(1);
            end
            if ((state_q == S_WAIT) && bus.done) begin
                result_q <= bus.d_out;
                if (!last_instr) begin
                    pc_q <= pc_q + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.d_instr = instr_q;
    assign bus.run     = run_c;
    assign bus.pc      = pc_q;
    assign bus.result  = result_q;
    assign bus.busy    = busy_c;
    assign bus.halted  = halted_c;
    assign bus.err     = err_c;
endmodule

// File: tb/tb_bitty_fetch.sv
// Bench for bitty_fetch: a scripted host plus a model bitty core; a monitor pops the
// expected instruction stream on every run pulse and compares against the presented word.
`timescale 1ns/1ps
module tb_bitty_fetch;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitty_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    bitty_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          run_count = 0;
    logic [15:0] model_mem [256];
    logic [15:0] exp_q [$];
    bit          core_hang = 1'b0;
    bit          core_early = 1'b0;
    int          core_lat = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each run pulse must carry the next expected word.
    always @(negedge clk) begin
        if (bus.run === 1'b1) begin
            run_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run: got instr %h expected no run", bus.d_instr);
            end else begin
                check("run_instr", bus.d_instr, exp_q.pop_front());
            end
        end
    end

    // Model core: done after core_lat cycles (0 = random 1..6), d_out = instr ^ 0xFFFF.
    initial begin : core_model
        logic [15:0] w;
        int          lat;
        bus.done  = 1'b0;
        bus.d_out = '0;
        forever begin
            @(negedge clk);
            if (bus.run === 1'b1 && !core_hang) begin
                w   = bus.d_instr;
                lat = (core_lat == 0) ? int'($urandom_range(1, 6)) : core_lat;
                if (core_early) begin
                    bus.done  = 1'b1;
                    bus.d_out = 16'hBAD0;
                    @(negedge clk);
                    bus.done = 1'b0;
                    repeat (lat - 1) @(negedge clk);
                end else begin
                    repeat (lat) @(negedge clk);
                end
                bus.done  = 1'b1;
                bus.d_out = w ^ 16'hFFFF;
                @(negedge clk);
                bus.done = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int addr, input logic [15:0] data, input bit expect_taken);
        bus.load_en   = 1'b1;
        bus.load_addr = addr[ADDR_W-1:0];
        bus.load_data = data;
        @(negedge clk);
        bus.load_en = 1'b0;
        if (expect_taken) model_mem[addr] = data;
    endtask

    task automatic start_prog(input int len, input int n_expected);
        for (int i = 0; i < n_expected; i++) exp_q.push_back(model_mem[i]);
        bus.start    = 1'b1;
        bus.prog_len = len[ADDR_W:0];
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n = 0;
        while (!(bus.halted === 1'b1 || bus.err === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.halted === 1'b1 || bus.err === 1'b1)) begin
            checks++;
            errors++;
            $display("FAIL %s_end: got no halt/err within %0d cycles expected halted", name, budget);
        end
    endtask

    task automatic finish_check(input string name, input int len, input int rc0);
        check({name, "_halted"}, bus.halted, 1);
        check({name, "_err"}, bus.err, 0);
        check({name, "_pc"}, bus.pc, len - 1);
        check({name, "_result"}, bus.result, model_mem[len-1] ^ 16'hFFFF);
        check({name, "_runs"}, run_count - rc0, len);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_d_instr"}, bus.d_instr, 0);
        check({name, "_run"}, bus.run, 0);
        check({name, "_pc"}, bus.pc, 0);
        check({name, "_result"}, bus.result, 0);
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_halted"}, bus.halted, 0);
        check({name, "_err"}, bus.err, 0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int rc;
        int n;
        int k;
        int seen;
        int len;
        reset         = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.prog_len  = '0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 256; i++) load(i, 16'($urandom), 1'b1);
        load(0, 16'h1111, 1'b1);
        load(1, 16'h2222, 1'b1);
        load(2, 16'h3333, 1'b1);

        // Basic three-instruction program.
        core_lat = 4;
        rc = run_count;
        start_prog(3, 3);
        wait_end("basic", 100);
        finish_check("basic", 3, rc);
        check("basic_result_value", bus.result, 16'hCCCC);

        // Zero-length program halts with no run.
        rc = run_count;
        start_prog(0, 0);
        check("zero_len_halted", bus.halted, 1);
        tick(4);
        check("zero_len_runs", run_count - rc, 0);

        // Watchdog: core never completes.
        core_hang = 1'b1;
        start_prog(2, 1);
        n = 0;
        while (bus.run !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        while (bus.err !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("err_latency", k, TIMEOUT + 2);
        check("err_pc", bus.pc, 0);
        check("err_halted", bus.halted, 0);
        rc = run_count;
        tick(6);
        check("err_no_more_runs", run_count - rc, 0);
        check("err_pending", exp_q.size(), 0);
        core_hang = 1'b0;
        rc = run_count;
        start_prog(3, 3);
        check("err_cleared", bus.err, 0);
        wait_end("after_err", 100);
        finish_check("after_err", 3, rc);

        // Write while busy is dropped; the same write in HALT takes effect.
        rc = run_count;
        start_prog(3, 3);
        tick(3);
        load(1, 16'hDEAD, 1'b0);
        wait_end("busy_write", 100);
        finish_check("busy_write", 3, rc);
        load(1, 16'hDEAD, 1'b1);
        rc = run_count;
        start_prog(3, 3);
        wait_end("halt_write", 100);
        finish_check("halt_write", 3, rc);

        // Reset during WAIT of the second instruction.
        start_prog(3, 3);
        seen = 0;
        n = 0;
        while (seen < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.run === 1'b1) seen++;
        end
        tick(2);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(8);
        rc = run_count;
        start_prog(3, 3);
        wait_end("rerun", 100);
        finish_check("rerun", 3, rc);

        // done during ISSUE and start during WAIT are both ignored.
        core_early = 1'b1;
        core_lat   = 3;
        rc = run_count;
        start_prog(3, 3);
        tick(2);
        bus.start    = 1'b1;
        bus.prog_len = 9'd1;
        tick(1);
        bus.start = 1'b0;
        wait_end("ignored", 100);
        finish_check("ignored", 3, rc);
        core_early = 1'b0;

        // Randomized programs with random core latency.
        core_lat = 0;
        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 3; j++) load(int'($urandom_range(0, 9)), 16'($urandom), 1'b1);
            len = int'($urandom_range(1, 10));
            rc = run_count;
            start_prog(len, len);
            wait_end("random", 200);
            finish_check("random", len, rc);
        end

        // Whole memory without pc wrap.
        core_lat = 1;
        rc = run_count;
        start_prog(256, 256);
        wait_end("full", 256 * 4 + 50);
        finish_check("full", 256, rc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
